// File: rtl/mss_fabric_pkg.sv
// Shared definitions for the MSS fabric bridges.
//   - state_e    : slave controller FSM states
//   - HTRANS_* / HSIZE_WORD : AHB-Lite encodings used by the decoders
//   - SLOT_LSB / SLOT_W     : position and width of the slot field in MSSHADDR
//   - OFFSET_W   : width of the peripheral word offset (MSSHADDR[11:2])
//   - TIMEOUT_W  : width of the ack timeout counter
package mss_fabric_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StDone,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HSIZE_WORD = 2'b10;

    localparam int unsigned SLOT_LSB  = 12;
    localparam int unsigned SLOT_W    = 4;
    localparam int unsigned OFFSET_W  = 10;
    localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/mss_fabric_timeout.sv
// Loadable down-counter with expire flag.
//   clk_i / rst_ni : clock, asynchronous active-low reset (count clears to 0)
//   load_i         : load load_val_i (takes priority over dec_i)
//   load_val_i     : value to load
//   dec_i          : decrement by one, saturating at zero
//   expired_o      : count is zero
module mss_fabric_timeout #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mss_fabric_slave_ctrl.sv
// AHB-Lite slave on the MSS fabric master port. Decodes each access into one of
// NUM_SLOTS peripheral register ports, runs a req/ack handshake with wait states,
// and answers ERROR for unmapped slots, non-word sizes or an ack timeout.
//   FAB_CLK / M2F_RESET_N : clock, asynchronous active-low reset
//   MSSH*                 : AHB-Lite slave interface (MSSHLOCK ignored)
//   per_req/we/addr/wdata : request side of the peripheral ports (per_req one-hot)
//   per_rdata / per_ack   : per-slot read data and acknowledge
//   err_pulse             : one-cycle pulse for every ERROR response
module mss_fabric_slave_ctrl
    import mss_fabric_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   FAB_CLK,
    input  logic                   M2F_RESET_N,
    input  logic [31:0]            MSSHADDR,
    input  logic [1:0]             MSSHTRANS,
    input  logic                   MSSHWRITE,
    input  logic [1:0]             MSSHSIZE,
    input  logic [31:0]            MSSHWDATA,
    input  logic                   MSSHLOCK,
    output logic                   MSSHREADY,
    output logic                   MSSHRESP,
    output logic [31:0]            MSSHRDATA,
    output logic [NUM_SLOTS-1:0]   per_req,
    output logic                   per_we,
    output logic [OFFSET_W-1:0]    per_addr,
    output logic [31:0]            per_wdata,
    input  logic [32*NUM_SLOTS-1:0] per_rdata,
    input  logic [NUM_SLOTS-1:0]   per_ack,
    output logic                   err_pulse
);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                write_q, write_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [31:0]         rdata_q, rdata_d;

    logic              xfer, legal, ack, expired, tmo_load, tmo_dec;
    logic [SLOT_W-1:0] slot_in;
    logic [31:0]       sel_rdata;
    logic              unused_inputs;

    assign unused_inputs = ^{MSSHLOCK, MSSHTRANS[0], MSSHADDR[31:16], MSSHADDR[1:0]};

    assign slot_in = MSSHADDR[SLOT_LSB +: SLOT_W];
    assign xfer    = MSSHTRANS[1] && MSSHREADY;
    assign legal   = (32'(slot_in) < NUM_SLOTS) && (MSSHSIZE == HSIZE_WORD);

    // Request and read-data mux are decoded from registered state so an
    // asynchronous reset drops per_req without waiting for a clock edge.
    always_comb begin
        per_req   = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                per_req[i] = (state_q == StReq);
                sel_rdata  = per_rdata[32*i +: 32];
            end
        end
    end

    // Acks on slots that are not being requested fall out of the mask.
    assign ack = |(per_ack & per_req);

    always_comb begin
        MSSHREADY = 1'b1;
        MSSHRESP  = 1'b0;
        err_pulse = 1'b0;
        case (state_q)
            StReq:  MSSHREADY = 1'b0;
            StErr1: begin
                MSSHREADY = 1'b0;
                MSSHRESP  = 1'b1;
                err_pulse = 1'b1;
            end
            StErr2: MSSHRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        write_d  = write_q;
        offset_d = offset_q;
        rdata_d  = rdata_q;
        tmo_load = 1'b0;
        tmo_dec  = 1'b0;
        case (state_q)
            // All ready states accept a new address phase, giving back-to-back issue.
            StIdle, StDone, StErr2: begin
                state_d = StIdle;
                if (xfer) begin
                    if (legal) begin
                        state_d  = StReq;
                        slot_d   = slot_in;
                        write_d  = MSSHWRITE;
                        offset_d = MSSHADDR[2 +: OFFSET_W];
                        tmo_load = 1'b1;
                    end else begin
                        state_d = StErr1;
                    end
                end
            end
            StReq: begin
                tmo_dec = 1'b1;
                if (ack) begin
                    state_d = StDone;
                    if (!write_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (expired) begin
                    state_d = StErr1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            write_q  <= 1'b0;
            offset_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            write_q  <= write_d;
            offset_q <= offset_d;
            rdata_q  <= rdata_d;
        end
    end

    // Loaded with TIMEOUT-1 so that it reads zero in the TIMEOUT-th REQ cycle.
    mss_fabric_timeout #(
        .Width (TIMEOUT_W)
    ) u_timeout (
        .clk_i      (FAB_CLK),
        .rst_ni     (M2F_RESET_N),
        .load_i     (tmo_load),
        .load_val_i (TIMEOUT_W'(TIMEOUT - 1)),
        .dec_i      (tmo_dec),
        .expired_o  (expired)
    );

    assign MSSHRDATA = rdata_q;
    assign per_we    = write_q;
    assign per_addr  = offset_q;
    assign per_wdata = MSSHWDATA;

endmodule

// File: tb/tb_mss_fabric_slave_ctrl.sv
// Self-checking bench for mss_fabric_slave_ctrl: directed cases followed by
// randomized transfers, checked against a transaction-level model.
module tb_mss_fabric_slave_ctrl;

    localparam int NS  = 4;
    localparam int TMO = 255;

    logic             FAB_CLK = 1'b0;
    logic             M2F_RESET_N;
    logic [31:0]      MSSHADDR;
    logic [1:0]       MSSHTRANS;
    logic             MSSHWRITE;
    logic [1:0]       MSSHSIZE;
    logic [31:0]      MSSHWDATA;
    logic             MSSHLOCK;
    logic             MSSHREADY;
    logic             MSSHRESP;
    logic [31:0]      MSSHRDATA;
    logic [NS-1:0]    per_req;
    logic             per_we;
    logic [9:0]       per_addr;
    logic [31:0]      per_wdata;
    logic [32*NS-1:0] per_rdata;
    logic [NS-1:0]    per_ack;
    logic             err_pulse;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] model_rdata = 32'h0;

    mss_fabric_slave_ctrl #(
        .NUM_SLOTS (NS),
        .TIMEOUT   (TMO)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .M2F_RESET_N (M2F_RESET_N),
        .MSSHADDR    (MSSHADDR),
        .MSSHTRANS   (MSSHTRANS),
        .MSSHWRITE   (MSSHWRITE),
        .MSSHSIZE    (MSSHSIZE),
        .MSSHWDATA   (MSSHWDATA),
        .MSSHLOCK    (MSSHLOCK),
        .MSSHREADY   (MSSHREADY),
        .MSSHRESP    (MSSHRESP),
        .MSSHRDATA   (MSSHRDATA),
        .per_req     (per_req),
        .per_we      (per_we),
        .per_addr    (per_addr),
        .per_wdata   (per_wdata),
        .per_rdata   (per_rdata),
        .per_ack     (per_ack),
        .err_pulse   (err_pulse)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Quiet-bus outputs: ready, OKAY, no request, no error pulse.
    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(MSSHREADY), 32'd1);
        check({tag, "_resp"},  32'(MSSHRESP),  32'd0);
        check({tag, "_req"},   32'(per_req),   32'd0);
        check({tag, "_err"},   32'(err_pulse), 32'd0);
        check({tag, "_rdata"}, MSSHRDATA,      model_rdata);
    endtask

    task automatic drive_rdata(input int slot, input logic [31:0] rdata);
        for (int i = 0; i < NS; i++) begin
            per_rdata[32*i +: 32] = (i == slot) ? rdata : $urandom;
        end
    endtask

    // Idle/busy cycles; ignored by the slave.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            MSSHTRANS = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            MSSHADDR  = $urandom;
            @(posedge FAB_CLK); #1;
            check_quiet("idle");
        end
    endtask

    // One transfer. Entered and left at #1 after a clock edge, in a ready cycle,
    // so consecutive calls issue back-to-back. delay: ack in the delay-th request
    // cycle; 0 or > TMO means the peripheral never answers.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wdata, input int delay, input logic [31:0] rdata);
        int            slot;
        bit            legal;
        bit            timed_out;
        logic [NS-1:0] req_exp;
        slot  = int'(addr[15:12]);
        legal = (slot < NS) && (size == 2'b10);
        check("addr_ready", 32'(MSSHREADY), 32'd1);
        MSSHADDR  = addr;
        MSSHTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        MSSHWRITE = wr;
        MSSHSIZE  = size;
        MSSHLOCK  = 1'($urandom);
        @(posedge FAB_CLK); #1;
        MSSHTRANS = 2'b00;
        MSSHADDR  = $urandom;
        MSSHWRITE = 1'($urandom);
        MSSHSIZE  = 2'($urandom);
        MSSHWDATA = wdata;
        if (!legal) begin
            check("dec_err1_req",   32'(per_req),   32'd0);
            check("dec_err1_ready", 32'(MSSHREADY), 32'd0);
            check("dec_err1_resp",  32'(MSSHRESP),  32'd1);
            check("dec_err1_pulse", 32'(err_pulse), 32'd1);
            @(posedge FAB_CLK); #1;
            check("dec_err2_req",   32'(per_req),   32'd0);
            check("dec_err2_ready", 32'(MSSHREADY), 32'd1);
            check("dec_err2_resp",  32'(MSSHRESP),  32'd1);
            check("dec_err2_pulse", 32'(err_pulse), 32'd0);
            check("dec_err2_rdata", MSSHRDATA,      model_rdata);
            return;
        end
        req_exp   = NS'(1) << slot;
        timed_out = 1'b1;
        for (int k = 1; k <= TMO; k++) begin
            check("req_onehot", 32'(per_req),   32'(req_exp));
            check("req_ready",  32'(MSSHREADY), 32'd0);
            check("req_resp",   32'(MSSHRESP),  32'd0);
            check("req_we",     32'(per_we),    32'(wr));
            check("req_addr",   32'(per_addr),  32'(addr[11:2]));
            check("req_wdata",  per_wdata,      wdata);
            if (k == delay) begin
                per_ack   = req_exp | (NS'($urandom) & ~req_exp);
                timed_out = 1'b0;
            end else begin
                per_ack = NS'($urandom) & ~req_exp;
            end
            drive_rdata(slot, rdata);
            @(posedge FAB_CLK); #1;
            per_ack = '0;
            if (!timed_out) break;
        end
        if (timed_out) begin
            check("tmo_err1_req",   32'(per_req),   32'd0);
            check("tmo_err1_ready", 32'(MSSHREADY), 32'd0);
            check("tmo_err1_resp",  32'(MSSHRESP),  32'd1);
            check("tmo_err1_pulse", 32'(err_pulse), 32'd1);
            per_ack = req_exp;  // late ack, must be ignored
            drive_rdata(slot, $urandom);
            @(posedge FAB_CLK); #1;
            per_ack = '0;
            check("tmo_err2_req",   32'(per_req),   32'd0);
            check("tmo_err2_ready", 32'(MSSHREADY), 32'd1);
            check("tmo_err2_resp",  32'(MSSHRESP),  32'd1);
            check("tmo_err2_pulse", 32'(err_pulse), 32'd0);
            check("tmo_err2_rdata", MSSHRDATA,      model_rdata);
        end else begin
            if (!wr) model_rdata = rdata;
            check_quiet("done");
        end
    endtask

    initial begin
        M2F_RESET_N = 1'b0;
        MSSHADDR    = '0;
        MSSHTRANS   = 2'b00;
        MSSHWRITE   = 1'b0;
        MSSHSIZE    = 2'b10;
        MSSHWDATA   = '0;
        MSSHLOCK    = 1'b0;
        per_rdata   = '0;
        per_ack     = '0;

        repeat (2) @(posedge FAB_CLK);
        #1;
        check_quiet("rst");
        check("rst_we",   32'(per_we),   32'd0);
        check("rst_addr", 32'(per_addr), 32'd0);
        #3 M2F_RESET_N = 1'b1;
        @(posedge FAB_CLK); #1;
        check_quiet("post_rst");

        // Directed cases from the plan; each follows the previous back-to-back.
        xfer(32'h0000_1010, 1'b0, 2'b10, 32'h0,         3,   32'hCAFE_0001);
        xfer(32'h0000_0000, 1'b1, 2'b10, 32'hDEAD_BEEF, 1,   32'h1234_5678);
        xfer(32'h0000_5000, 1'b0, 2'b10, 32'h0,         1,   32'h0);
        xfer(32'h0000_0004, 1'b0, 2'b01, 32'h0,         1,   32'h0);
        xfer(32'h0000_3ffc, 1'b0, 2'b10, 32'h0,         2,   32'h0BAD_F00D);
        idle(2);
        xfer(32'h0000_2000, 1'b0, 2'b10, 32'h0,         0,   32'h0);
        xfer(32'h0000_2008, 1'b0, 2'b10, 32'h0,         TMO, 32'h5A5A_A5A5);
        idle(1);

        // Asynchronous reset in the middle of a request.
        MSSHADDR  = 32'h0000_3008;
        MSSHTRANS = 2'b10;
        MSSHWRITE = 1'b0;
        MSSHSIZE  = 2'b10;
        @(posedge FAB_CLK); #1;
        MSSHTRANS = 2'b00;
        check("arst_pre_req", 32'(per_req), 32'b1000);
        #2 M2F_RESET_N = 1'b0;
        model_rdata = 32'h0;
        #1;
        check_quiet("arst");
        check("arst_we",   32'(per_we),   32'd0);
        check("arst_addr", 32'(per_addr), 32'd0);
        #2 M2F_RESET_N = 1'b1;
        @(posedge FAB_CLK); #1;
        check_quiet("arst_rel");
        xfer(32'h0000_3008, 1'b0, 2'b10, 32'h0, 2, 32'h7777_0003);

        // Randomized transfers with random gaps (or none).
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          dly;
            a  = $urandom;
            a[15:12] = 4'($urandom_range(0, 5));
            sz = 2'b10;
            if ($urandom_range(0, 7) == 0) begin
                sz = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            end
            dly = ($urandom_range(0, 24) == 0) ? 0 : $urandom_range(1, 5);
            xfer(a, 1'($urandom), sz, $urandom, dly, $urandom);
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mss_fabric_slave_ctrl.md
# mss_fabric_slave_ctrl

Fabric-side AHB-Lite slave controller on the MSS fabric master port (MSSH* bus). It decodes each MSS access into one of NUM_SLOTS fabric peripheral register ports and runs a req/ack handshake with the selected peripheral. It inserts wait states until the peripheral acknowledges, and returns an AHB ERROR response on an unmapped slot, a non-word size or an ack timeout. It is the single point through which Cortex-M3 firmware reaches camera, GPIO and timing logic in the FPGA fabric.

## Interface
Parameters:
- NUM_SLOTS, 4, peripheral ports; 1..16
- TIMEOUT, 255, max REQ cycles without ack before error; 1..255

Ports:
- FAB_CLK  in  1  fabric clock from MSS
- M2F_RESET_N  in  1  asynchronous active-low reset
- MSSHADDR  in  32  AHB address
- MSSHTRANS  in  2  AHB transfer type
- MSSHWRITE  in  1  1 = write
- MSSHSIZE  in  2  transfer size; only 2'b10 (word) legal
- MSSHWDATA  in  32  write data (data phase)
- MSSHLOCK  in  1  ignored
- MSSHREADY  out  1  slave ready (HREADYOUT)
- MSSHRESP  out  1  1 = ERROR
- MSSHRDATA  out  32  read data
- per_req  out  NUM_SLOTS  one-hot request, held until ack
- per_we  out  1  write strobe qualifier
- per_addr  out  10  word offset MSSHADDR[11:2]
- per_wdata  out  32  = MSSHWDATA, valid while per_req != 0
- per_rdata  in  32*NUM_SLOTS  slot i at [32i+31:32i]
- per_ack  in  NUM_SLOTS  slot done; sampled only while that slot's req is high
- err_pulse  out  1  one-cycle pulse per ERROR response

## Operation
- Transfer: MSSHTRANS[1]=1 (NONSEQ/SEQ) while MSSHREADY=1; BUSY/IDLE are ignored.
- Decode: slot = MSSHADDR[15:12]. Error if slot >= NUM_SLOTS or MSSHSIZE != 2'b10. MSSHADDR[31:16] and [1:0] are ignored.
- Address phase: registers slot, write, offset.
- FSM states:
  - IDLE: MSSHREADY=1, RESP=0. Legal transfer -> REQ. Illegal -> ERR1.
  - REQ: per_req[slot]=1, MSSHREADY=0, counter increments.
    - Ack: capture per_rdata slot into MSSHRDATA (reads only; writes leave MSSHRDATA unchanged), drop req next cycle -> DONE.
    - Counter == TIMEOUT with no ack: -> ERR1. The ack check takes priority over the timeout.
  - DONE: MSSHREADY=1, RESP=0. New transfer in this cycle -> REQ/ERR1 (back-to-back), else IDLE.
  - ERR1: MSSHREADY=0, RESP=1, err_pulse=1 -> ERR2.
  - ERR2: MSSHREADY=1, RESP=1. Transfer sampled here is accepted normally (REQ/ERR1), else IDLE.
- per_req never asserts on an error path. An ack on a non-requested slot is ignored.
- Reset (asynchronous, any state): MSSHREADY=1, MSSHRESP=0, MSSHRDATA=0, per_req=0, per_we=0, per_addr=0, err_pulse=0, counter=0, state IDLE. A peripheral mid-handshake sees req drop immediately.

## Timing
- Address phase at cycle N; per_req high from N+1.
- Ack at N+1 (combinational ack) -> MSSHREADY=1 with data at N+2. Minimum one wait state.
- Ack at N+k -> ready at N+k+1.
- Timeout: req high N+1..N+TIMEOUT; ERR1 at N+TIMEOUT+1; ERR2 at N+TIMEOUT+2.
- Error from decode: ERR1 at N+1, ERR2 at N+2.
- MSSHRDATA holds its last value outside DONE. MSSHWDATA must remain stable while MSSHREADY=0 (AHB rule).

## Structure
- Shared package mss_fabric_pkg: state enum, HTRANS/HSIZE encodings, SLOT_LSB=12, OFFSET_W=10, TIMEOUT_W=8.
- One sub-module, mss_fabric_timeout: loadable down-counter with expire flag, reused by later fabric bridges.

## Test plan
- Read slot 1, offset 0x004 (addr 0x0000_1010), ack at N+3 with rdata 0xCAFE_0001 -> per_req=4'b0010 for N+1..N+3; MSSHREADY=1, MSSHRDATA=0xCAFE_0001, RESP=0 at N+4.
- Write 0xDEAD_BEEF to slot 0 at addr 0x0000_0000, combinational ack -> per_we=1, per_wdata=0xDEAD_BEEF at N+1; ready at N+2.
- Access slot 5 with NUM_SLOTS=4, then MSSHSIZE=2'b01 to slot 0 -> each gives no per_req, ERR1/ERR2 two-cycle ERROR, err_pulse once.
- Slot 2 never acks, TIMEOUT=255 -> req high 255 cycles, then ERROR; a late ack on slot 2 is ignored.
- Back-to-back transfers issued in the DONE cycle and in the ERR2 cycle -> second transfer's per_req asserts on the next cycle, no idle gap.
- M2F_RESET_N low during REQ -> per_req=0 and MSSHREADY=1 without waiting for a clock edge; after release a fresh read completes normally.
